rr_dff_write_arbiter: RTL and testbench

Round-robin arbiter that shares one W-bit register among N requesters. The register is built from positive-edge D flip-flops with asynchronous active-high reset. Each cycle the arbiter grants at most one pending requester and loads that requester's data into the shared register. The grant is registered and lasts one cycle. This block sits in front of a shared configuration or status register written by several independent producers.

---
 rtl/rr_dff_write_arbiter_pkg.sv | 25 ++
 rtl/rr_dff_write_arbiter_pick.sv | 44 ++++
 rtl/rr_dff_write_arbiter.sv | 81 ++++++++
 tb/tb_rr_dff_write_arbiter.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/rr_dff_write_arbiter_pkg.sv
// Shared definitions for the round-robin shared-register write arbiter.
package rr_dff_write_arbiter_pkg;

  localparam int unsigned DEF_RST_VAL = 32'd0;

  // Index width for n items; never less than one bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) begin
        w = i + 1;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

  // Bit pos of the one-hot encoding of idx.
  function automatic logic onehot_bit(input int idx, input int pos);
    return (idx == pos) ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/rr_dff_write_arbiter_pick.sv
// Combinational round-robin selector: rotate requests so ptr is at bit 0,
// take the lowest set bit, then rotate the winning index back.
module rr_pick
  import rr_dff_write_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  eff,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win_oh,
  output logic [IW-1:0] win_idx,
  output logic          win_vld
);

  logic [N-1:0] rot_s;
  int           k_s;
  int           idx_s;

  // Rotate eff so that requester ptr lands on bit 0.
  always_comb begin
    rot_s = '0;
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        rot_s[k] = (((int'(ptr) + k) % N) == j) ? eff[j] : rot_s[k];
      end
    end
  end

  // Lowest set rotated bit wins; map it back to a requester index.
  always_comb begin
    k_s = 0;
    for (int k = N - 1; k >= 0; k--) begin
      k_s = rot_s[k] ? k : k_s;
    end
    win_vld = |rot_s;
    idx_s   = (int'(ptr) + k_s) % N;
    win_idx = IW'(idx_s);
    for (int j = 0; j < N; j++) begin
      win_oh[j] = win_vld & onehot_bit(idx_s, j);
    end
  end

endmodule

// File: rtl/rr_dff_write_arbiter.sv
// Round-robin arbiter sharing one W-bit register among N writers; one
// registered grant per cycle, winner's lane loaded into q at the same edge.
module rr_dff_write_arbiter
  import rr_dff_write_arbiter_pkg::*;
#(
  parameter int            N       = 4,
  parameter int            W       = 8,
  parameter logic [W-1:0]  RST_VAL = W'(DEF_RST_VAL)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [N-1:0]          req,
  input  logic [N*W-1:0]        wdata,
  output logic [N-1:0]          gnt,
  output logic [W-1:0]          q,
  output logic                  q_vld,
  output logic [clog2(N)-1:0]   owner
);

  localparam int IW = clog2(N);

  logic [N-1:0]  gnt_r;
  logic [W-1:0]  q_r;
  logic          q_vld_r;
  logic [IW-1:0] owner_r;
  logic [IW-1:0] ptr_r;

  logic [N-1:0]  eff_s;
  logic [N-1:0]  win_oh_s;
  logic [IW-1:0] win_idx_s;
  logic          win_vld_s;
  logic [W-1:0]  lane_s;
  logic [IW-1:0] nxt_ptr_s;

  // A requester granted last cycle is masked for one edge so it can drop req.
  assign eff_s = req & ~gnt_r;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .eff     (eff_s),
    .ptr     (ptr_r),
    .win_oh  (win_oh_s),
    .win_idx (win_idx_s),
    .win_vld (win_vld_s)
  );

  // Winner's data lane and the pointer one past it, wrapping at N-1.
  always_comb begin
    lane_s = '0;
    for (int k = 0; k < N; k++) begin
      lane_s = (win_idx_s == IW'(k)) ? wdata[k*W +: W] : lane_s;
    end
    nxt_ptr_s = (win_idx_s == IW'(N - 1)) ? '0 : win_idx_s + IW'(1);
  end

  // Grant, shared register, owner and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_r   <= '0;
      q_r     <= RST_VAL;
      q_vld_r <= 1'b0;
      owner_r <= '0;
      ptr_r   <= '0;
    end else if (en && win_vld_s) begin
      gnt_r   <= win_oh_s;
      q_r     <= lane_s;
      q_vld_r <= 1'b1;
      owner_r <= win_idx_s;
      ptr_r   <= nxt_ptr_s;
    end else begin
      gnt_r   <= '0;
      q_vld_r <= 1'b0;
    end
  end

  assign gnt   = gnt_r;
  assign q     = q_r;
  assign q_vld = q_vld_r;
  assign owner = owner_r;

endmodule

// File: tb/tb_rr_dff_write_arbiter.sv
// Directed bench: a 4-requester instance driven from a vector table plus
// hand sequences, and a 3-requester instance for non-power-of-2 wrap.
module tb_rr_dff_write_arbiter;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic        q_vld;
  logic [1:0]  owner;

  logic        en3;
  logic [2:0]  req3;
  logic [23:0] wdata3;
  logic [2:0]  gnt3;
  logic [7:0]  q3;
  logic        q_vld3;
  logic [1:0]  owner3;

  int total;
  int bad;

  rr_dff_write_arbiter #(.N(4), .W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .wdata(wdata),
    .gnt(gnt), .q(q), .q_vld(q_vld), .owner(owner)
  );

  rr_dff_write_arbiter #(.N(3), .W(8), .RST_VAL(8'h5A)) dut3 (
    .clk(clk), .rst(rst), .en(en3), .req(req3), .wdata(wdata3),
    .gnt(gnt3), .q(q3), .q_vld(q_vld3), .owner(owner3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  req;
    logic        en;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic        vld;
    logic [1:0]  owner;
  } vec_t;

  vec_t vecs [22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check4(input string tag, input logic [3:0] eg, input logic [7:0] eq,
                        input logic ev, input logic [1:0] eo);
    check({tag, " gnt"},   32'(gnt),   32'(eg));
    check({tag, " q"},     32'(q),     32'(eq));
    check({tag, " q_vld"}, 32'(q_vld), 32'(ev));
    check({tag, " owner"}, 32'(owner), 32'(eo));
  endtask

  initial begin
    // all request; each drops during its grant, then re-raises
    vecs[0]  = '{4'b1111, 1'b1, 32'h13121110, 4'b0001, 8'h10, 1'b1, 2'd0};
    vecs[1]  = '{4'b1110, 1'b1, 32'h13121110, 4'b0010, 8'h11, 1'b1, 2'd1};
    vecs[2]  = '{4'b1101, 1'b1, 32'h13121110, 4'b0100, 8'h12, 1'b1, 2'd2};
    vecs[3]  = '{4'b1011, 1'b1, 32'h13121110, 4'b1000, 8'h13, 1'b1, 2'd3};
    vecs[4]  = '{4'b0111, 1'b1, 32'h13121110, 4'b0001, 8'h10, 1'b1, 2'd0};
    vecs[5]  = '{4'b0000, 1'b1, 32'h13121110, 4'b0000, 8'h10, 1'b0, 2'd0};
    // single requester 2; lane changes after the grant must not reach q
    vecs[6]  = '{4'b0100, 1'b1, 32'h13A51110, 4'b0100, 8'hA5, 1'b1, 2'd2};
    vecs[7]  = '{4'b0000, 1'b1, 32'h13FF1110, 4'b0000, 8'hA5, 1'b0, 2'd2};
    // req[0] held: granted every other cycle
    vecs[8]  = '{4'b0001, 1'b1, 32'h13FF1155, 4'b0001, 8'h55, 1'b1, 2'd0};
    vecs[9]  = '{4'b0001, 1'b1, 32'h13FF1155, 4'b0000, 8'h55, 1'b0, 2'd0};
    vecs[10] = '{4'b0001, 1'b1, 32'h13FF1155, 4'b0001, 8'h55, 1'b1, 2'd0};
    vecs[11] = '{4'b0001, 1'b1, 32'h13FF1155, 4'b0000, 8'h55, 1'b0, 2'd0};
    vecs[12] = '{4'b0001, 1'b1, 32'h13FF1155, 4'b0001, 8'h55, 1'b1, 2'd0};
    vecs[13] = '{4'b0000, 1'b1, 32'h13FF1155, 4'b0000, 8'h55, 1'b0, 2'd0};
    // enable low: requests wait, q holds
    for (int i = 14; i < 19; i++) begin
      vecs[i] = '{4'b1010, 1'b0, 32'hD0C0B0A0, 4'b0000, 8'h55, 1'b0, 2'd0};
    end
    vecs[19] = '{4'b1010, 1'b1, 32'hD0C0B0A0, 4'b0010, 8'hB0, 1'b1, 2'd1};
    vecs[20] = '{4'b1000, 1'b1, 32'hD0C0B0A0, 4'b1000, 8'hD0, 1'b1, 2'd3};
    vecs[21] = '{4'b0000, 1'b1, 32'hD0C0B0A0, 4'b0000, 8'hD0, 1'b0, 2'd3};

    total = 0;
    bad   = 0;
    rst    = 1'b1;
    en     = 1'b1;
    req    = 4'b0000;
    wdata  = 32'h0;
    en3    = 1'b1;
    req3   = 3'b000;
    wdata3 = 24'h222120;

    #2;
    check4("reset", 4'b0000, 8'h00, 1'b0, 2'd0);
    check("reset q3", 32'(q3), 32'h5A);
    #6 rst = 1'b0;

    for (int i = 0; i < 22; i++) begin
      req   = vecs[i].req;
      en    = vecs[i].en;
      wdata = vecs[i].wdata;
      @(posedge clk);
      #1;
      check4($sformatf("v%0d", i), vecs[i].gnt, vecs[i].q, vecs[i].vld, vecs[i].owner);
    end

    // reset mid-grant clears outputs without a clock edge
    req   = 4'b1111;
    en    = 1'b1;
    wdata = 32'hD0C0B0A0;
    @(posedge clk);
    #1;
    check4("pre_rst", 4'b0001, 8'hA0, 1'b1, 2'd0);
    #2 rst = 1'b1;
    #1;
    check4("async_rst", 4'b0000, 8'h00, 1'b0, 2'd0);
    check("async_rst q3", 32'(q3), 32'h5A);
    @(posedge clk);
    #1;
    check4("held_rst", 4'b0000, 8'h00, 1'b0, 2'd0);
    #3 rst = 1'b0;
    // aborted grant is not served: pointer restarts at 0, requester 0 wins again
    @(posedge clk);
    #1;
    check4("post_rst", 4'b0001, 8'hA0, 1'b1, 2'd0);
    req = 4'b0000;

    // N=3: continuous requests give 0,1,2,0,... with a seamless 2 -> 0 wrap
    req3 = 3'b111;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("n3 c%0d gnt", k),   32'(gnt3),   32'(3'b001 << (k % 3)));
      check($sformatf("n3 c%0d q", k),     32'(q3),     32'h20 + 32'(k % 3));
      check($sformatf("n3 c%0d owner", k), 32'(owner3), 32'(k % 3));
      check($sformatf("n3 c%0d q_vld", k), 32'(q_vld3), 32'd1);
    end
    req3 = 3'b000;
    @(posedge clk);
    #1;
    check("n3 idle gnt", 32'(gnt3), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
